// File: rtl/load_align_unit.sv
// Load-data stage: issues one word-aligned bus read, then extracts and
// sign/zero-extends the addressed byte, halfword or word for writeback.
module load_align_unit #(
    parameter int LOAD_OP_WIDTH = 3,
    parameter int XLEN          = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [LOAD_OP_WIDTH-1:0] LOADop,
    input  logic [XLEN-1:0]          addr,
    output logic                     mem_valid,
    output logic [XLEN-1:0]          mem_addr,
    output logic [3:0]               mem_wstrb,
    input  logic                     mem_ready,
    input  logic [XLEN-1:0]          mem_rdata,
    output logic [XLEN-1:0]          result,
    output logic                     done,
    output logic                     misaligned,
    output logic                     busy
);

    // Load encodings follow the RISC-V funct3 values produced by the load decoder.
    localparam logic [LOAD_OP_WIDTH-1:0] OP_LB  = LOAD_OP_WIDTH'(3'b000);
    localparam logic [LOAD_OP_WIDTH-1:0] OP_LH  = LOAD_OP_WIDTH'(3'b001);
    localparam logic [LOAD_OP_WIDTH-1:0] OP_LW  = LOAD_OP_WIDTH'(3'b010);
    localparam logic [LOAD_OP_WIDTH-1:0] OP_LBU = LOAD_OP_WIDTH'(3'b100);
    localparam logic [LOAD_OP_WIDTH-1:0] OP_LHU = LOAD_OP_WIDTH'(3'b101);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]               state;
    logic [LOAD_OP_WIDTH-1:0] op_q;
    logic [1:0]               off_q;
    logic [XLEN-1:0]          rdata_q;

    logic [LOAD_OP_WIDTH-1:0] op_norm;
    logic                     is_misaligned;
    logic [7:0]               byte_sel;
    logic [15:0]              half_sel;
    logic [XLEN-1:0]          extracted;

    assign mem_wstrb = 4'b0000;
    assign busy      = (state != S_IDLE);

    // Unknown opcodes collapse to LW so an X from the decoder never reaches state.
    always_comb begin
        op_norm = OP_LW;
        case (LOADop)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_norm = LOADop;
            default:                             op_norm = OP_LW;
        endcase
        is_misaligned = (((op_norm == OP_LH) || (op_norm == OP_LHU)) && addr[0]) ||
                        ((op_norm == OP_LW) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        byte_sel = rdata_q[7:0];
        case (off_q)
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (op_q)
            OP_LB:   extracted = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            OP_LBU:  extracted = {{(XLEN-8){1'b0}}, byte_sel};
            OP_LH:   extracted = {{(XLEN-16){half_sel[15]}}, half_sel};
            OP_LHU:  extracted = {{(XLEN-16){1'b0}}, half_sel};
            default: extracted = rdata_q;
        endcase
    end

    // done and misaligned default low so each is a single-cycle pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            op_q       <= OP_LW;
            off_q      <= 2'b00;
            rdata_q    <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            result     <= '0;
            done       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_misaligned) begin
                            misaligned <= 1'b1;
                        end else begin
                            op_q      <= op_norm;
                            off_q     <= addr[1:0];
                            mem_addr  <= {addr[XLEN-1:2], 2'b00};
                            mem_valid <= 1'b1;
                            state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        rdata_q   <= mem_rdata;
                        mem_valid <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    result <= extracted;
                    done   <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    mem_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: directed cases plus randomized loads
// checked against a byte-lane arithmetic reference model.
module tb_load_align_unit;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [2:0]  LOADop;
    logic [31:0] addr;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] result;
    logic        done;
    logic        misaligned;
    logic        busy;

    typedef struct {
        bit          mis;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cycle_count = 0;
    logic [31:0] model_result = 32'h0;

    load_align_unit #(.LOAD_OP_WIDTH(3), .XLEN(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .LOADop(LOADop), .addr(addr),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .result(result),
        .done(done), .misaligned(misaligned), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int size_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit is_mis(input logic [2:0] op, input logic [31:0] a);
        return (int'(a[1:0]) % size_of(op)) != 0;
    endfunction

    // Reference: shift the addressed lane down, mask to size, extend if signed.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] data);
        int          size = size_of(op);
        int          off = int'(a[1:0]);
        logic [31:0] mask;
        logic [31:0] v;
        if (size == 4) return data;
        mask = (size == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (data >> (8 * off)) & mask;
        if (((op == LB) || (op == LH)) && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    // Monitor: every done/misaligned pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn) begin
            if (done && misaligned) checkOutput("done_and_mis_together", 32'd1, 32'd0);
            if (done || misaligned) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pulse", {30'd0, done, misaligned}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("pulse_kind", {31'd0, misaligned}, {31'd0, e.mis});
                    checkOutput(e.mis ? "mis_result_hold" : "load_result", result, e.val);
                    checkOutput("pulse_cycle", cycle_count, e.cyc);
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            LOADop    = 3'($urandom);
            addr      = $urandom;
            @(negedge clk);
        end
        mem_ready = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where the result is visible.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] data,
                                 input int delay, input bit poke);
        exp_t e;
        start     = 1'b1;
        LOADop    = op;
        addr      = a;
        mem_ready = 1'b0;
        if (is_mis(op, a)) begin
            e.mis = 1'b1;
            e.val = model_result;
            e.cyc = cycle_count + 1;
            exp_q.push_back(e);
            @(negedge clk);
            start = 1'b0;
            repeat (2) begin
                checkOutput("mis_no_bus", {31'd0, mem_valid}, 32'd0);
                checkOutput("mis_not_busy", {31'd0, busy}, 32'd0);
                @(negedge clk);
            end
            return;
        end
        e.mis = 1'b0;
        e.val = ref_load(op, a, data);
        e.cyc = cycle_count + 3 + delay;
        exp_q.push_back(e);
        model_result = e.val;
        @(negedge clk);
        for (int k = 0; k <= delay; k++) begin
            start  = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            LOADop = 3'($urandom);
            addr   = $urandom;
            checkOutput("req_valid", {31'd0, mem_valid}, 32'd1);
            checkOutput("req_addr", mem_addr, {a[31:2], 2'b00});
            checkOutput("req_wstrb", {28'd0, mem_wstrb}, 32'd0);
            checkOutput("req_busy", {31'd0, busy}, 32'd1);
            if (k == delay) begin
                mem_ready = 1'b1;
                mem_rdata = data;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        start     = poke ? 1'b1 : 1'b0;
        checkOutput("resp_valid_low", {31'd0, mem_valid}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30 && !done; i++) @(negedge clk);
        checkOutput("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic directed_load(input string name, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] data, input int delay, input logic [31:0] want);
        applyStimulus(op, a, data, delay, 1'b0);
        checkOutput(name, result, want);
        idle_cycles(1);
    endtask

    task automatic abort_load(input logic [31:0] a);
        start  = 1'b1;
        LOADop = LW;
        addr   = a;
        @(negedge clk);
        start = 1'b0;
        checkOutput("abort_req_valid", {31'd0, mem_valid}, 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("abort_valid_low", {31'd0, mem_valid}, 32'd0);
        checkOutput("abort_busy_low", {31'd0, busy}, 32'd0);
        checkOutput("abort_done_low", {31'd0, done}, 32'd0);
        checkOutput("abort_result_reset", result, 32'd0);
        model_result = 32'h0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        idle_cycles(2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  op;
        resetn    = 1'b0;
        start     = 1'b0;
        LOADop    = 3'd0;
        addr      = 32'd0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;

        repeat (5) begin
            @(negedge clk);
            start     = 1'($urandom_range(0, 1));
            LOADop    = 3'($urandom);
            addr      = $urandom;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            checkOutput("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
            checkOutput("rst_mem_addr", mem_addr, 32'd0);
            checkOutput("rst_result", result, 32'd0);
            checkOutput("rst_done_mis_busy", {29'd0, done, misaligned, busy}, 32'd0);
        end
        start     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] directed loads");
        directed_load("lw_first", LW, 32'h100, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        directed_load("lb_off0", LB, 32'h0, 32'h80F17F01, 0, 32'h00000001);
        directed_load("lb_off1", LB, 32'h1, 32'h80F17F01, 1, 32'h0000007F);
        directed_load("lb_off2", LB, 32'h2, 32'h80F17F01, 0, 32'hFFFFFFF1);
        directed_load("lb_off3", LB, 32'h3, 32'h80F17F01, 2, 32'hFFFFFF80);
        directed_load("lbu_off3", LBU, 32'h3, 32'h80F17F01, 0, 32'h00000080);
        directed_load("lh_202", LH, 32'h202, 32'h8001FFFE, 0, 32'hFFFF8001);
        directed_load("lhu_202", LHU, 32'h202, 32'h8001FFFE, 0, 32'h00008001);
        directed_load("lh_200", LH, 32'h200, 32'h8001FFFE, 0, 32'hFFFFFFFE);
        directed_load("mis_lh_301", LH, 32'h301, 32'h12345678, 0, 32'hFFFFFFFE);
        directed_load("mis_lw_302", LW, 32'h302, 32'h12345678, 0, 32'hFFFFFFFE);
        directed_load("lw_wait5", LW, 32'h400, 32'hCAFEF00D, 5, 32'hCAFEF00D);
        directed_load("undef_op_as_lw", 3'd7, 32'h404, 32'h0BADC0DE, 0, 32'h0BADC0DE);

        $display("[TB] abort and back-to-back");
        abort_load(32'h500);
        directed_load("after_abort", LW, 32'h504, 32'h11223344, 1, 32'h11223344);
        applyStimulus(LHU, 32'h602, 32'hA5A55A5A, 3, 1'b1);
        checkOutput("poke_ignored", result, 32'h0000A5A5);
        applyStimulus(LB, 32'h701, 32'h00FF0000 | 32'h0000C300, 0, 1'b0);
        checkOutput("b2b_first", result, 32'hFFFFFFC3);
        applyStimulus(LH, 32'h702, 32'h7FFF0000, 0, 1'b0);
        checkOutput("b2b_second", result, 32'h00007FFF);
        idle_cycles(2);

        $display("[TB] randomized loads");
        for (int n = 0; n < 80; n++) begin
            op = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'(int'(a[1:0]) & ~(size_of(op) - 1));
            applyStimulus(op, a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(10);
        checkOutput("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Multicycle load-data stage directly downstream of the load decoder. Consumes LOADop and the effective address.
- Performs one word-aligned read on the native memory bus and extracts the addressed byte, halfword or word. Sign- or zero-extends it and presents the 32-bit result for register writeback.
- Flags misaligned accesses without issuing a bus cycle, so the control FSM can raise a load-address-misaligned trap.

Parameters:
- LOAD_OP_WIDTH, 3, width of LOADop; encodings are the `LOAD_OP_LB/LH/LW/LBU/LHU macros from riscv_defines.vh.
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- start  input  1  one-cycle request pulse; sampled only in IDLE
- LOADop  input  LOAD_OP_WIDTH  load type from the load decoder; sampled with start
- addr  input  32  effective byte address; sampled with start
- mem_valid  output  1  bus request strobe
- mem_addr  output  32  word-aligned bus address, {addr[31:2],2'b00}
- mem_wstrb  output  4  always 4'b0000 (read)
- mem_ready  input  1  bus completion; mem_rdata valid in the same cycle
- mem_rdata  input  32  bus read data
- result  output  32  aligned and extended load data
- done  output  1  one-cycle pulse: result valid
- misaligned  output  1  one-cycle pulse: access rejected
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values (async, resetn=0): state=IDLE; mem_valid=0; mem_addr=0; result=0; done=0; misaligned=0; busy=0.
- States: IDLE, REQ, RESP.
- IDLE, start=1: capture LOADop, addr[1:0] and word address into registers.
  - Misaligned when LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - If misaligned: next cycle misaligned=1, stay IDLE, no bus cycle, result unchanged.
  - Otherwise go to REQ.
- Undefined LOADop (not one of the five encodings) with start=1: treated as LW for alignment and extraction. Decoder X is not propagated into state.
- REQ: mem_valid=1 and mem_addr held stable until mem_ready=1.
  - On the mem_ready cycle: register mem_rdata into the data register, drop mem_valid the next cycle, go to RESP.
  - mem_ready asserted while mem_valid=0 is ignored.
- RESP, one cycle: result <= extracted value; done=1 this cycle; return to IDLE.
  - Base latency: start to done is 3 cycles when mem_ready is high in the first REQ cycle. Each wait cycle adds one.
- Extraction (off = captured addr[1:0]):
  - LB/LBU: byte = rdata[8*off+7 -: 8]; LB sign-extends bit 7, LBU zero-extends.
  - LH/LHU: half = rdata[16*off[1]+15 -: 16]; LH sign-extends bit 15, LHU zero-extends.
  - LW: rdata unchanged.
- result holds its value until the next successful load completes.
- start while busy=1 is ignored; captured operands are not disturbed.
- done and misaligned are never high in the same cycle, and each is high for exactly one cycle.
- resetn deasserted mid-transaction (REQ or RESP): immediate return to IDLE, mem_valid=0, no done pulse. The bus side must tolerate an abandoned request.
- A start in the IDLE cycle immediately following done is accepted (back-to-back loads). Minimum spacing is therefore 3 cycles.

Test Plan:
- Reset: hold resetn=0 with random inputs -> all outputs 0. Release, then start LW addr=0x100, mem_rdata=0xDEADBEEF, ready on first REQ cycle -> mem_addr=0x100, done on cycle 3, result=0xDEADBEEF.
- Byte lanes: mem_rdata=0x80F17F01.
  - LB at offsets 0..3 -> 0x00000001, 0x0000007F, 0xFFFFFFF1, 0xFFFFFF80.
  - LBU at offset 3 -> 0x00000080.
- Halfwords: mem_rdata=0x8001FFFE.
  - LH addr=0x202 -> 0xFFFF8001; LHU addr=0x202 -> 0x00008001.
  - LH addr=0x200 -> 0xFFFFFFFE; mem_addr=0x200 in all cases.
- Misaligned: LH addr=0x301 -> misaligned pulse one cycle after start, mem_valid never asserted, result unchanged. Repeat with LW addr=0x302 -> same response.
- Wait states and abort:
  - LW with mem_ready delayed 5 cycles -> mem_valid and mem_addr stable throughout, done on cycle 8.
  - Second run: resetn pulsed low during REQ -> mem_valid=0 immediately, no done, and the next start completes normally.
- Back-to-back and ignored start:
  - start reasserted while busy -> ignored, single done.
  - start in the cycle after done -> second load accepted and completes with correct data.
